// File: rtl/endp_addr_codec_if.sv
// Endpoint-address codec bus: an encode path (flat ID -> endpoint address)
// and an independent decode path (endpoint address -> flat ID).
interface endp_addr_codec_if #(
    parameter int NEw = 4,
    parameter int EAw = 4
);
    logic           enc_valid;
    logic [NEw-1:0] enc_id;
    logic [EAw-1:0] enc_code;
    logic           enc_ok;
    logic           dec_valid;
    logic [EAw-1:0] dec_code;
    logic [NEw-1:0] dec_id;
    logic           dec_ok;
    logic           dec_err;

    // Requester side: traffic generator / packet injector.
    modport master (
        output enc_valid, enc_id, dec_valid, dec_code,
        input  enc_code, enc_ok, dec_id, dec_ok, dec_err
    );

    // Codec side.
    modport slave (
        input  enc_valid, enc_id, dec_valid, dec_code,
        output enc_code, enc_ok, dec_id, dec_ok, dec_err
    );
endinterface

// File: rtl/endp_addr_codec.sv
// Registered endpoint-address codec for the NoC. Converts flat endpoint IDs
// into topology-specific packed addresses and back, one result per cycle per
// path with a single register stage. Illegal inputs yield zeroed outputs.
module endp_addr_codec #(
    parameter string TOPOLOGY = "MESH",
    parameter int    T1       = 4,
    parameter int    T2       = 4,
    parameter int    T3       = 1,
    parameter int    NE       = 16,
    parameter int    EAw      = 4
) (
    input  logic             clk,
    input  logic             reset,
    endp_addr_codec_if.slave bus
);
    localparam int NEw = (NE > 1) ? $clog2(NE) : 1;

    localparam bit IS_GRID  = (TOPOLOGY == "MESH") || (TOPOLOGY == "TORUS");
    localparam bit IS_CHAIN = (TOPOLOGY == "RING") || (TOPOLOGY == "LINE");
    localparam bit IS_TREE  = (TOPOLOGY == "FATTREE") || (TOPOLOGY == "TREE");

    // Field widths; a count of 1 needs no bits at all.
    localparam int XW = (T1 > 1) ? $clog2(T1) : 0;
    localparam int YW = (T2 > 1) ? $clog2(T2) : 0;
    localparam int LW = (T3 > 1) ? $clog2(T3) : 0;

    // Total width of the packed address; anything above it must be zero.
    localparam int PW = IS_GRID  ? (XW + YW + LW) :
                        IS_CHAIN ? (XW + LW) :
                        IS_TREE  ? (T2 * XW) : XW;

    localparam logic [31:0] X_MASK = (32'd1 << XW) - 32'd1;
    localparam logic [31:0] Y_MASK = (32'd1 << YW) - 32'd1;
    localparam logic [31:0] L_MASK = (32'd1 << LW) - 32'd1;

    // Inputs widened to 32 bits so all arithmetic shares one width.
    logic [31:0] enc_id_w;
    logic [31:0] dec_code_w;
    assign enc_id_w   = 32'(bus.enc_id);
    assign dec_code_w = 32'(bus.dec_code);

    // Per-topology combinational results.
    logic [31:0] enc_code_raw;   // packed fields, valid only when the ID is in range
    logic [31:0] dec_id_raw;     // reassembled ID, valid only when the code is legal
    logic        dec_field_bad;  // some field exceeds its count

    if (IS_GRID) begin : g_grid
        logic [31:0] e_r;
        logic [31:0] e_l;
        logic [31:0] d_x;
        logic [31:0] d_y;
        logic [31:0] d_l;

        // Split ID into router (x,y) and local port, pack as {l,y,x}.
        always_comb begin
            e_r          = enc_id_w / 32'(T3);
            e_l          = enc_id_w % 32'(T3);
            enc_code_raw = (e_r % 32'(T1)) | ((e_r / 32'(T1)) << XW) | (e_l << (XW + YW));
        end

        // Unpack {l,y,x}, range-check each field, rebuild (y*T1+x)*T3+l.
        always_comb begin
            d_x           = dec_code_w & X_MASK;
            d_y           = (dec_code_w >> XW) & Y_MASK;
            d_l           = (dec_code_w >> (XW + YW)) & L_MASK;
            dec_field_bad = (d_x >= 32'(T1)) || (d_y >= 32'(T2)) || (d_l >= 32'(T3));
            dec_id_raw    = (d_y * 32'(T1) + d_x) * 32'(T3) + d_l;
        end
    end else if (IS_CHAIN) begin : g_chain
        logic [31:0] d_x;
        logic [31:0] d_l;

        // Router index in the low field, local port above it.
        always_comb begin
            enc_code_raw = (enc_id_w / 32'(T3)) | ((enc_id_w % 32'(T3)) << XW);
        end

        // Unpack {l,x}, range-check, rebuild x*T3+l.
        always_comb begin
            d_x           = dec_code_w & X_MASK;
            d_l           = (dec_code_w >> XW) & L_MASK;
            dec_field_bad = (d_x >= 32'(T1)) || (d_l >= 32'(T3));
            dec_id_raw    = d_x * 32'(T3) + d_l;
        end
    end else if (IS_TREE) begin : g_tree
        logic [31:0] e_rem;
        logic [31:0] d_dig;

        // Base-K digits of the ID, least significant digit in the lowest field.
        always_comb begin
            e_rem        = enc_id_w;
            enc_code_raw = '0;
            for (int i = 0; i < T2; i++) begin
                enc_code_raw = enc_code_raw | ((e_rem % 32'(T1)) << (i * XW));
                e_rem        = e_rem / 32'(T1);
            end
        end

        // Horner evaluation from the most significant digit down.
        always_comb begin
            dec_id_raw    = '0;
            dec_field_bad = 1'b0;
            d_dig         = '0;
            for (int i = T2 - 1; i >= 0; i--) begin
                d_dig = (dec_code_w >> (i * XW)) & X_MASK;
                if (d_dig >= 32'(T1)) begin
                    dec_field_bad = 1'b1;
                end
                dec_id_raw = dec_id_raw * 32'(T1) + d_dig;
            end
        end
    end else begin : g_star
        // Star addresses are the ID itself.
        always_comb begin
            enc_code_raw  = enc_id_w;
            dec_id_raw    = dec_code_w;
            dec_field_bad = 1'b0;
        end
    end

    logic enc_hit;
    logic dec_bad;
    assign enc_hit = bus.enc_valid && (enc_id_w < 32'(NE));
    assign dec_bad = dec_field_bad || ((dec_code_w >> PW) != 32'd0) || (dec_id_raw >= 32'(NE));

    logic [EAw-1:0] enc_code_reg;
    logic           enc_ok_reg;
    logic [NEw-1:0] dec_id_reg;
    logic           dec_ok_reg;
    logic           dec_err_reg;

    // Output stage captures every cycle; idle or illegal inputs load zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_code_reg <= '0;
            enc_ok_reg   <= 1'b0;
            dec_id_reg   <= '0;
            dec_ok_reg   <= 1'b0;
            dec_err_reg  <= 1'b0;
        end else begin
            enc_code_reg <= enc_hit ? EAw'(enc_code_raw) : '0;
            enc_ok_reg   <= enc_hit;
            dec_id_reg   <= (bus.dec_valid && !dec_bad) ? NEw'(dec_id_raw) : '0;
            dec_ok_reg   <= bus.dec_valid && !dec_bad;
            dec_err_reg  <= bus.dec_valid && dec_bad;
        end
    end

    assign bus.enc_code = enc_code_reg;
    assign bus.enc_ok   = enc_ok_reg;
    assign bus.dec_id   = dec_id_reg;
    assign bus.dec_ok   = dec_ok_reg;
    assign bus.dec_err  = dec_err_reg;
endmodule

// File: tb/tb_endp_addr_codec.sv
// Bench for endp_addr_codec: seven topology configurations run side by side,
// checked against an arithmetic reference model of the address formats.
module tb_endp_addr_codec;
    localparam int NCFG = 7;
    localparam int TP_MESH = 0, TP_TORUS = 1, TP_RING = 2, TP_LINE = 3;
    localparam int TP_FATTREE = 4, TP_TREE = 5, TP_STAR = 6;

    // Configuration table (index = instance number).
    function automatic int cfg_topo(int k);
        case (k)
            0: return TP_MESH;    1: return TP_TORUS;  2: return TP_RING;
            3: return TP_LINE;    4: return TP_FATTREE; 5: return TP_TREE;
            default: return TP_STAR;
        endcase
    endfunction
    function automatic int cfg_t1(int k);
        case (k) 0: return 3; 1: return 4; 2: return 5; 3: return 3; 4: return 4; 5: return 3; default: return 8; endcase
    endfunction
    function automatic int cfg_t2(int k);
        case (k) 0: return 2; 1: return 4; 4: return 2; 5: return 2; default: return 1; endcase
    endfunction
    function automatic int cfg_t3(int k);
        case (k) 0: return 2; 2: return 3; default: return 1; endcase
    endfunction
    function automatic int cfg_ne(int k);
        case (k) 0: return 12; 1: return 16; 2: return 15; 3: return 3; 4: return 16; 5: return 9; default: return 8; endcase
    endfunction
    function automatic int cfg_eaw(int k);
        case (k) 1: return 5; 2: return 6; 3: return 2; default: return 4; endcase
    endfunction
    function automatic int cfg_new(int k);
        return (cfg_ne(k) > 1) ? $clog2(cfg_ne(k)) : 1;
    endfunction

    function automatic int fw(int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    // Reference encoder: -1 for an ID outside 0..NE-1.
    function automatic int model_enc(int k, int id);
        int t1, t2, t3, r, v, rem;
        t1 = cfg_t1(k); t2 = cfg_t2(k); t3 = cfg_t3(k);
        if (id < 0 || id >= cfg_ne(k)) return -1;
        case (cfg_topo(k))
            TP_MESH, TP_TORUS: begin
                r = id / t3;
                return (r % t1) + (r / t1) * (1 << fw(t1)) + (id % t3) * (1 << (fw(t1) + fw(t2)));
            end
            TP_RING, TP_LINE:
                return (id / t3) + (id % t3) * (1 << fw(t1));
            TP_FATTREE, TP_TREE: begin
                v = 0; rem = id;
                for (int i = 0; i < t2; i++) begin
                    v += (rem % t1) * (1 << (i * fw(t1)));
                    rem = rem / t1;
                end
                return v;
            end
            default: return id;
        endcase
    endfunction

    // Reference decoder: a code is legal exactly when some ID encodes to it.
    function automatic int model_dec(int k, int code);
        for (int i = 0; i < cfg_ne(k); i++)
            if (model_enc(k, i) == code) return i;
        return -1;
    endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic       enc_valid  [NCFG];
    logic [7:0] enc_id     [NCFG];
    logic       dec_valid  [NCFG];
    logic [7:0] dec_code   [NCFG];
    logic [7:0] enc_code_o [NCFG];
    logic       enc_ok_o   [NCFG];
    logic [7:0] dec_id_o   [NCFG];
    logic       dec_ok_o   [NCFG];
    logic       dec_err_o  [NCFG];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int NEW_I = cfg_new(gi);
        localparam int EAW_I = cfg_eaw(gi);
        endp_addr_codec_if #(.NEw(NEW_I), .EAw(EAW_I)) ifc ();
        assign ifc.enc_valid  = enc_valid[gi];
        assign ifc.enc_id     = enc_id[gi][NEW_I-1:0];
        assign ifc.dec_valid  = dec_valid[gi];
        assign ifc.dec_code   = dec_code[gi][EAW_I-1:0];
        assign enc_code_o[gi] = 8'(ifc.enc_code);
        assign enc_ok_o[gi]   = ifc.enc_ok;
        assign dec_id_o[gi]   = 8'(ifc.dec_id);
        assign dec_ok_o[gi]   = ifc.dec_ok;
        assign dec_err_o[gi]  = ifc.dec_err;
        if (gi == 0) begin : g_dut
            endp_addr_codec #(.TOPOLOGY("MESH"), .T1(3), .T2(2), .T3(2), .NE(12), .EAw(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end else if (gi == 1) begin : g_dut
            endp_addr_codec #(.TOPOLOGY("TORUS"), .T1(4), .T2(4), .T3(1), .NE(16), .EAw(5)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end else if (gi == 2) begin : g_dut
            endp_addr_codec #(.TOPOLOGY("RING"), .T1(5), .T2(1), .T3(3), .NE(15), .EAw(6)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end else if (gi == 3) begin : g_dut
            endp_addr_codec #(.TOPOLOGY("LINE"), .T1(3), .T2(1), .T3(1), .NE(3), .EAw(2)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end else if (gi == 4) begin : g_dut
            endp_addr_codec #(.TOPOLOGY("FATTREE"), .T1(4), .T2(2), .T3(1), .NE(16), .EAw(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end else if (gi == 5) begin : g_dut
            endp_addr_codec #(.TOPOLOGY("TREE"), .T1(3), .T2(2), .T3(1), .NE(9), .EAw(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end else begin : g_dut
            endp_addr_codec #(.TOPOLOGY("STAR"), .T1(8), .T2(1), .T3(1), .NE(8), .EAw(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
        end
    end

    task automatic idle_inputs();
        for (int k = 0; k < NCFG; k++) begin
            enc_valid[k] = 1'b0; enc_id[k] = 8'd0;
            dec_valid[k] = 1'b0; dec_code[k] = 8'd0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NCFG; k++) begin
            enc_valid[k] = 1'b1; enc_id[k] = 8'd1;
            dec_valid[k] = 1'b1; dec_code[k] = 8'd1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_cmp++;
            if ({enc_ok_o[k], enc_code_o[k], dec_ok_o[k], dec_err_o[k], dec_id_o[k]} !== 19'd0) begin
                n_bad++;
                $display("FAIL reset_state cfg%0d: got enc_ok=%0d code=%0h dec_ok=%0d err=%0d id=%0d, want all 0",
                         k, enc_ok_o[k], enc_code_o[k], dec_ok_o[k], dec_err_o[k], dec_id_o[k]);
            end
            $display("reset cfg%0d: outputs held at zero check done", k);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_spec_vectors();
        idle_inputs();
        enc_valid[0] = 1'b1; enc_id[0] = 8'd7;  dec_valid[0] = 1'b1; dec_code[0] = 8'hC;
        enc_valid[4] = 1'b1; enc_id[4] = 8'd9;  dec_valid[4] = 1'b1; dec_code[4] = 8'b1001;
        enc_valid[6] = 1'b1; enc_id[6] = 8'd5;  dec_valid[6] = 1'b1; dec_code[6] = 8'd5;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({enc_ok_o[0], enc_code_o[0]} !== {1'b1, 8'hC}) begin
            n_bad++; $display("FAIL mesh_enc7: got ok=%0d code=%0h, want ok=1 code=c", enc_ok_o[0], enc_code_o[0]);
        end
        n_cmp++;
        if ({dec_ok_o[0], dec_err_o[0], dec_id_o[0]} !== {1'b1, 1'b0, 8'd7}) begin
            n_bad++; $display("FAIL mesh_dec_c: got ok=%0d err=%0d id=%0d, want ok=1 err=0 id=7", dec_ok_o[0], dec_err_o[0], dec_id_o[0]);
        end
        n_cmp++;
        if ({enc_ok_o[4], enc_code_o[4]} !== {1'b1, 8'b1001}) begin
            n_bad++; $display("FAIL fattree_enc9: got ok=%0d code=%0h, want ok=1 code=9", enc_ok_o[4], enc_code_o[4]);
        end
        n_cmp++;
        if ({dec_ok_o[4], dec_err_o[4], dec_id_o[4]} !== {1'b1, 1'b0, 8'd9}) begin
            n_bad++; $display("FAIL fattree_dec9: got ok=%0d err=%0d id=%0d, want ok=1 err=0 id=9", dec_ok_o[4], dec_err_o[4], dec_id_o[4]);
        end
        n_cmp++;
        if ({enc_ok_o[6], enc_code_o[6], dec_ok_o[6], dec_id_o[6]} !== {1'b1, 8'd5, 1'b1, 8'd5}) begin
            n_bad++; $display("FAIL star_5: got enc ok=%0d code=%0h dec ok=%0d id=%0d, want 1/5/1/5", enc_ok_o[6], enc_code_o[6], dec_ok_o[6], dec_id_o[6]);
        end
        $display("spec: mesh 7->%0h, mesh c->%0d, ft 9->%0h, ft 9->%0d, star 5->%0h", enc_code_o[0], dec_id_o[0], enc_code_o[4], dec_id_o[4], enc_code_o[6]);

        idle_inputs();
        enc_valid[0] = 1'b1; enc_id[0] = 8'd12; dec_valid[0] = 1'b1; dec_code[0] = 8'h3;
        enc_valid[4] = 1'b0; enc_id[4] = 8'd3;  dec_valid[4] = 1'b0; dec_code[4] = 8'd5;
        dec_valid[6] = 1'b1; dec_code[6] = 8'd8;
        dec_valid[1] = 1'b1; dec_code[1] = 8'h10;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({enc_ok_o[0], enc_code_o[0]} !== {1'b0, 8'd0}) begin
            n_bad++; $display("FAIL mesh_enc_out_of_range: got ok=%0d code=%0h, want ok=0 code=0", enc_ok_o[0], enc_code_o[0]);
        end
        n_cmp++;
        if ({dec_ok_o[0], dec_err_o[0], dec_id_o[0]} !== {1'b0, 1'b1, 8'd0}) begin
            n_bad++; $display("FAIL mesh_dec_x_too_big: got ok=%0d err=%0d id=%0d, want ok=0 err=1 id=0", dec_ok_o[0], dec_err_o[0], dec_id_o[0]);
        end
        n_cmp++;
        if ({enc_ok_o[4], enc_code_o[4], dec_ok_o[4], dec_err_o[4], dec_id_o[4]} !== 19'd0) begin
            n_bad++; $display("FAIL fattree_idle: got enc ok=%0d code=%0h dec ok=%0d err=%0d id=%0d, want all 0",
                              enc_ok_o[4], enc_code_o[4], dec_ok_o[4], dec_err_o[4], dec_id_o[4]);
        end
        n_cmp++;
        if ({dec_ok_o[6], dec_err_o[6], dec_id_o[6]} !== {1'b0, 1'b1, 8'd0}) begin
            n_bad++; $display("FAIL star_dec_high_bit: got ok=%0d err=%0d id=%0d, want ok=0 err=1 id=0", dec_ok_o[6], dec_err_o[6], dec_id_o[6]);
        end
        n_cmp++;
        if ({dec_ok_o[1], dec_err_o[1], dec_id_o[1]} !== {1'b0, 1'b1, 8'd0}) begin
            n_bad++; $display("FAIL torus_dec_unused_msb: got ok=%0d err=%0d id=%0d, want ok=0 err=1 id=0", dec_ok_o[1], dec_err_o[1], dec_id_o[1]);
        end
        $display("spec: mesh enc 12 ok=%0d, mesh dec 3 err=%0d, star dec 8 err=%0d, torus dec 10 err=%0d",
                 enc_ok_o[0], dec_err_o[0], dec_err_o[6], dec_err_o[1]);
    endtask

    task automatic test_random(int cycles);
        logic [7:0] x_ecode [NCFG];
        logic       x_eok   [NCFG];
        logic [7:0] x_did   [NCFG];
        logic       x_dok   [NCFG];
        logic       x_derr  [NCFG];
        int         errs;
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < NCFG; k++) begin
                int e, d, id_v, code_v;
                id_v = int'($urandom_range(0, (1 << cfg_new(k)) - 1));
                if ($urandom_range(0, 1) == 1)
                    code_v = model_enc(k, int'($urandom_range(0, cfg_ne(k) - 1)));
                else
                    code_v = int'($urandom_range(0, (1 << cfg_eaw(k)) - 1));
                enc_valid[k] = ($urandom_range(0, 3) != 0);
                dec_valid[k] = ($urandom_range(0, 3) != 0);
                enc_id[k]    = 8'(id_v);
                dec_code[k]  = 8'(code_v);
                e = model_enc(k, id_v);
                d = model_dec(k, code_v);
                x_eok[k]   = enc_valid[k] && (e >= 0);
                x_ecode[k] = x_eok[k] ? 8'(e) : 8'd0;
                x_dok[k]   = dec_valid[k] && (d >= 0);
                x_derr[k]  = dec_valid[k] && (d < 0);
                x_did[k]   = x_dok[k] ? 8'(d) : 8'd0;
            end
            @(posedge clk);
            #1;
            errs = 0;
            for (int k = 0; k < NCFG; k++) begin
                n_cmp++;
                if ({enc_ok_o[k], enc_code_o[k]} !== {x_eok[k], x_ecode[k]}) begin
                    n_bad++; errs++;
                    $display("FAIL rand_enc cyc%0d cfg%0d: got ok=%0d code=%0h, want ok=%0d code=%0h",
                             c, k, enc_ok_o[k], enc_code_o[k], x_eok[k], x_ecode[k]);
                end
                n_cmp++;
                if ({dec_ok_o[k], dec_err_o[k], dec_id_o[k]} !== {x_dok[k], x_derr[k], x_did[k]}) begin
                    n_bad++; errs++;
                    $display("FAIL rand_dec cyc%0d cfg%0d: got ok=%0d err=%0d id=%0d, want ok=%0d err=%0d id=%0d",
                             c, k, dec_ok_o[k], dec_err_o[k], dec_id_o[k], x_dok[k], x_derr[k], x_did[k]);
                end
            end
            $display("rand cyc%0d: %0d configs checked, %0d differences", c, NCFG, errs);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NCFG; k++) begin
            int ne;
            ne = cfg_ne(k);
            idle_inputs();
            @(posedge clk);
            #1;
            for (int t = 0; t <= ne; t++) begin
                enc_valid[k] = (t < ne);
                enc_id[k]    = (t < ne) ? 8'(t) : 8'd0;
                dec_valid[k] = enc_ok_o[k];
                dec_code[k]  = enc_code_o[k];
                @(posedge clk);
                #1;
                if (t < ne) begin
                    n_cmp++;
                    if ({enc_ok_o[k], enc_code_o[k]} !== {1'b1, 8'(model_enc(k, t))}) begin
                        n_bad++;
                        $display("FAIL b2b_enc cfg%0d id=%0d: got ok=%0d code=%0h, want ok=1 code=%0h",
                                 k, t, enc_ok_o[k], enc_code_o[k], model_enc(k, t));
                    end
                end
                if (t >= 1) begin
                    n_cmp++;
                    if ({dec_ok_o[k], dec_err_o[k], dec_id_o[k]} !== {1'b1, 1'b0, 8'(t - 1)}) begin
                        n_bad++;
                        $display("FAIL b2b_roundtrip cfg%0d id=%0d: got ok=%0d err=%0d id=%0d, want ok=1 err=0 id=%0d",
                                 k, t - 1, dec_ok_o[k], dec_err_o[k], dec_id_o[k], t - 1);
                    end
                    $display("b2b cfg%0d: id %0d round trip -> %0d", k, t - 1, dec_id_o[k]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < NCFG; k++) begin
            enc_valid[k] = 1'b1; enc_id[k] = 8'(cfg_ne(k) - 1);
            dec_valid[k] = 1'b1; dec_code[k] = 8'(model_enc(k, 0));
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_cmp++;
            if ({enc_ok_o[k], enc_code_o[k], dec_ok_o[k], dec_err_o[k], dec_id_o[k]} !== 19'd0) begin
                n_bad++;
                $display("FAIL async_reset cfg%0d: got enc ok=%0d code=%0h dec ok=%0d err=%0d id=%0d, want all 0",
                         k, enc_ok_o[k], enc_code_o[k], dec_ok_o[k], dec_err_o[k], dec_id_o[k]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_cmp++;
            if ({enc_ok_o[k], dec_ok_o[k], dec_err_o[k]} !== 3'd0) begin
                n_bad++;
                $display("FAIL post_reset_idle cfg%0d: got enc_ok=%0d dec_ok=%0d dec_err=%0d, want 0",
                         k, enc_ok_o[k], dec_ok_o[k], dec_err_o[k]);
            end
            enc_valid[k] = 1'b1; enc_id[k] = 8'(cfg_ne(k) - 1);
            dec_valid[k] = 1'b1; dec_code[k] = 8'(model_enc(k, 0));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_cmp++;
            if ({enc_ok_o[k], enc_code_o[k], dec_ok_o[k], dec_err_o[k], dec_id_o[k]} !==
                {1'b1, 8'(model_enc(k, cfg_ne(k) - 1)), 1'b1, 1'b0, 8'd0}) begin
                n_bad++;
                $display("FAIL first_after_reset cfg%0d: got enc ok=%0d code=%0h dec ok=%0d err=%0d id=%0d, want 1/%0h/1/0/0",
                         k, enc_ok_o[k], enc_code_o[k], dec_ok_o[k], dec_err_o[k], dec_id_o[k], model_enc(k, cfg_ne(k) - 1));
            end
            $display("reset_mid cfg%0d: first result enc=%0h dec=%0d", k, enc_code_o[k], dec_id_o[k]);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_spec_vectors();
        test_random(60);
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
